tt_sweep_checker: RTL

- Sequential stimulus/response engine for small combinational blocks in the DataFlow_Level family.
- Drives every input combination onto the DUT inputs, holds each combination for a fixed number of cycles, then samples the DUT's single output bit.
- Compares each sample against a parameterised expected truth table, counts mismatches and reports pass/fail.
- Synthesisable replacement for hand-written delay-driven benches; the default parameters target the 3-input function X = A | ~(B|C).

---
 rtl/tt_sweep_pkg.sv | 19 +
 rtl/tt_sweep_checker_if.sv | 26 ++
 rtl/tt_hold_counter.sv | 32 +++
 rtl/tt_sweep_checker.sv | 110 +++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_sweep_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Expected truth table of circuit01: X = A | ~(B | C), index {A,B,C}.
    localparam logic [7:0] EXP_TT_CIRCUIT01 = 8'hF1;

    // Width of the hold counter; never narrower than one bit.
    function automatic int hold_cnt_width(input int hold);
        return (hold <= 2) ? 1 : $clog2(hold);
    endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Stimulus/response and result signals between the sweep checker and its DUT side.
interface tt_sweep_checker_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            dut_in;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail_idx;

    // Checker side: receives start and the DUT response, drives stimulus and results.
    modport master (
        input  start, dut_in,
        output vec_out, busy, done, pass, err_cnt, fail_valid, first_fail_idx
    );

    // Environment side: requests sweeps, returns the DUT response, observes results.
    modport slave (
        output start, dut_in,
        input  vec_out, busy, done, pass, err_cnt, fail_valid, first_fail_idx
    );
endinterface

// File: rtl/tt_hold_counter.sv
// Counts the hold period of each vector and flags the sample cycle.
module tt_hold_counter #(
    parameter int HOLD = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sample_tick
);
    import tt_sweep_pkg::*;

    localparam int             W    = hold_cnt_width(HOLD);
    localparam logic [W-1:0]   LAST = W'(HOLD - 1);

    logic [W-1:0] cnt_reg;

    // The HOLD-th enabled cycle after a clear is the sample cycle.
    assign sample_tick = en && (cnt_reg == LAST);

    // Count enabled cycles, wrapping to zero on the sample cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (sample_tick) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector onto a small combinational DUT, samples its output
// after a settling period and checks it against an expected truth table.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int                  N_IN   = 3,
    parameter int                  HOLD   = 5,
    parameter logic [2**N_IN-1:0]  EXP_TT = EXP_TT_CIRCUIT01
) (
    input  logic            clk,
    input  logic            rst,
    tt_sweep_checker_if.master bus
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t          state_reg;
    state_t          state_next;
    logic [N_IN-1:0] vec_reg;
    logic [N_IN:0]   err_cnt_reg;
    logic            fail_valid_reg;
    logic [N_IN-1:0] first_fail_reg;

    logic start_go;
    logic sample_tick;
    logic last_vec;
    logic mismatch;
    logic busy;
    logic done;
    logic pass;

    // A start is honoured only when no sweep is running.
    assign start_go = bus.start && (state_reg != APPLY);
    assign last_vec = (vec_reg == LAST_VEC);
    assign mismatch = (bus.dut_in != EXP_TT[vec_reg]);

    tt_hold_counter #(
        .HOLD (HOLD)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_go),
        .en          (state_reg == APPLY),
        .sample_tick (sample_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: run on start, finish after sampling the last vector.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                if (sample_tick && last_vec) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stimulus vector and result registers; cleared by a new run, updated on sample cycles.
    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            vec_reg        <= '0;
            err_cnt_reg    <= '0;
            fail_valid_reg <= 1'b0;
            first_fail_reg <= '0;
        end else if ((state_reg == APPLY) && sample_tick) begin
            if (mismatch) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
                if (!fail_valid_reg) begin
                    first_fail_reg <= vec_reg;
                    fail_valid_reg <= 1'b1;
                end
            end
            if (!last_vec) begin
                vec_reg <= vec_reg + 1'b1;
            end
        end
    end

    // Status outputs decoded from the state; pass is only meaningful once done.
    always_comb begin
        busy = (state_reg == APPLY);
        done = (state_reg == DONE);
        pass = done && (err_cnt_reg == '0);
    end

    assign bus.vec_out        = vec_reg;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.err_cnt        = err_cnt_reg;
    assign bus.fail_valid     = fail_valid_reg;
    assign bus.first_fail_idx = first_fail_reg;

endmodule
